// File: rtl/srcz_gen_pkg.sv
// Shared blitter definitions for the source-Z path: phrase geometry,
// accumulator width and the span sequencing states.
package srcz_gen_pkg;

    localparam int PIX_PER_PHRASE = 4;
    localparam int ZW             = 16;
    localparam int ZACC_W         = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lane enable mask for 0..4 active pixels, lane 0 filled first.
    function automatic logic [PIX_PER_PHRASE-1:0] lane_mask(input logic [2:0] npix);
        case (npix)
            3'd0:    lane_mask = 4'b0000;
            3'd1:    lane_mask = 4'b0001;
            3'd2:    lane_mask = 4'b0011;
            3'd3:    lane_mask = 4'b0111;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/srcz_gen_zlane_add.sv
// One phrase lane: integer Z of pixel `lane` in the phrase, i.e. the upper
// half of z_acc + lane*zinc (mod 2^32), forced to zero when the lane is off.
module zlane_add
    import srcz_gen_pkg::*;
(
    input  logic [ZACC_W-1:0] z_acc,
    input  logic [ZACC_W-1:0] zinc,
    input  logic [1:0]        lane,
    input  logic              en,
    output logic [ZW-1:0]     z
);

    logic [ZACC_W-1:0] offset;
    logic [ZACC_W-1:0] sum;

    // Small lane multiples need only a shift and at most one add.
    always_comb begin
        offset = '0;
        case (lane)
            2'd1:    offset = zinc;
            2'd2:    offset = {zinc[ZACC_W-2:0], 1'b0};
            2'd3:    offset = zinc + {zinc[ZACC_W-2:0], 1'b0};
            default: offset = '0;
        endcase
        sum = z_acc + offset;
        z   = en ? sum[ZACC_W-1:ZW] : '0;
    end

endmodule

// File: rtl/srcz_gen.sv
// Source-Z generator: steps a 16.16 Z along a span and presents up to four
// integer Z values per phrase to the Z comparator.
module srcz_gen
    import srcz_gen_pkg::*;
(
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [ZACC_W-1:0]         zstart,
    input  logic [ZACC_W-1:0]         zinc,
    input  logic [15:0]               count,
    input  logic                      phrase_mode,
    output logic                      srcz_valid,
    input  logic                      srcz_ready,
    output logic [2*ZW-1:0]           srczplo,
    output logic [2*ZW-1:0]           srczphi,
    output logic [PIX_PER_PHRASE-1:0] pix_en,
    output logic                      busy,
    output logic                      done
);

    state_t            state_q, state_d;
    logic [ZACC_W-1:0] z_acc, z_acc_d;
    logic [ZACC_W-1:0] zinc_r, zinc_d;
    logic [15:0]       rem, rem_d;
    logic              pm_r, pm_d;

    logic [2:0]        npix;
    logic [ZACC_W-1:0] step_inc;
    logic [ZW-1:0]     lane_z [PIX_PER_PHRASE];
    logic              run;

    assign run        = (state_q == RUN);
    assign npix       = !pm_r ? 3'd1 : (rem >= 16'd4) ? 3'd4 : rem[2:0];
    assign pix_en     = run ? lane_mask(npix) : '0;
    assign srcz_valid = run;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign srczplo    = {lane_z[1], lane_z[0]};
    assign srczphi    = {lane_z[3], lane_z[2]};

    for (genvar k = 0; k < PIX_PER_PHRASE; k++) begin : g_lane
        zlane_add u_lane (
            .z_acc (z_acc),
            .zinc  (zinc_r),
            .lane  (2'(k)),
            .en    (pix_en[k]),
            .z     (lane_z[k])
        );
    end

    always_comb begin
        step_inc = '0;
        case (npix)
            3'd1:    step_inc = zinc_r;
            3'd2:    step_inc = {zinc_r[ZACC_W-2:0], 1'b0};
            3'd3:    step_inc = zinc_r + {zinc_r[ZACC_W-2:0], 1'b0};
            3'd4:    step_inc = {zinc_r[ZACC_W-3:0], 2'b00};
            default: step_inc = '0;
        endcase
    end

    // A phrase transfers on any edge where srcz_valid && srcz_ready; while
    // valid is high and ready low, the phrase and all state are held. A load
    // overrides a same-cycle transfer and silently drops the old span.
    always_comb begin
        state_d = state_q;
        z_acc_d = z_acc;
        zinc_d  = zinc_r;
        rem_d   = rem;
        pm_d    = pm_r;
        if (load) begin
            if (count != 16'd0) begin
                state_d = RUN;
                z_acc_d = zstart;
                zinc_d  = zinc;
                rem_d   = count;
                pm_d    = phrase_mode;
            end else begin
                state_d = DONE;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (srcz_ready) begin
                        z_acc_d = z_acc + step_inc;
                        rem_d   = rem - {13'd0, npix};
                        if (rem == {13'd0, npix}) state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= IDLE;
            z_acc   <= '0;
            zinc_r  <= '0;
            rem     <= '0;
            pm_r    <= 1'b0;
        end else begin
            state_q <= state_d;
            z_acc   <= z_acc_d;
            zinc_r  <= zinc_d;
            rem     <= rem_d;
            pm_r    <= pm_d;
        end
    end

endmodule

// File: doc/srcz_gen.md
# srcz_gen

Source-Z generator for the blitter Z-buffer path. It interpolates a 16.16 fixed-point Z along a span and presents per-pixel integer Z as 4-pixel phrases on srczplo/srczphi, the inputs consumed by the Z comparator. It advances one phrase (or one pixel) per accepted handshake and reports span completion to the blitter sequencer.

## Interface
Parameters:
- none. Phrase width is fixed at 4 pixels × 16 bits (see package).

Ports:
- sys_clk  in  1  blitter clock
- reset  in  1  synchronous, active-high
- load  in  1  start a span; samples zstart, zinc, count, phrase_mode
- zstart  in  32  initial Z, 16.16 unsigned
- zinc  in  32  per-pixel Z increment, 16.16, two's complement
- count  in  16  span length in pixels
- phrase_mode  in  1  1: up to 4 pixels per step; 0: 1 pixel per step
- srcz_valid  out  1  phrase on srczplo/srczphi/pix_en is valid
- srcz_ready  in  1  downstream accepts the current phrase
- srczplo  out  32  lane 0 Z in [15:0], lane 1 Z in [31:16]
- srczphi  out  32  lane 2 Z in [15:0], lane 3 Z in [31:16]
- pix_en  out  4  per-lane valid mask, bit n = lane n
- busy  out  1  span in progress
- done  out  1  one-cycle pulse at span completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE: srcz_valid=0. load=1 with count≠0 → z_acc←zstart, zinc_r←zinc, rem←count, pm_r←phrase_mode, go to RUN. load=1 with count=0 → DONE.
- RUN: srcz_valid=1. npix = pm_r ? min(4,rem) : 1.
- Lane k (k<npix) = (z_acc + k·zinc_r)[31:16]. 2·zinc is a shift; 3·zinc = zinc + 2·zinc. All sums are modulo 2^32.
- Lanes k≥npix output 0x0000. pix_en = (1<<npix)−1.
- Handshake (srcz_valid & srcz_ready): z_acc ← z_acc + npix·zinc_r (mod 2^32), rem ← rem − npix. If rem−npix = 0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = state≠IDLE.
- Backpressure: while srcz_valid & !srcz_ready, all outputs and state are held.
- load in RUN or DONE aborts the current span and restarts per the IDLE rules. load has priority over a simultaneous handshake, and the aborted span gets no done pulse.
- zinc and zstart changes outside a load cycle have no effect.

## Timing
- Reset values: srcz_valid=0, srczplo=0, srczphi=0, pix_en=0, busy=0, done=0; state=IDLE, z_acc=0, rem=0.
- Reset mid-span returns to IDLE on the next edge; no done pulse.
- Outputs depend only on registered state. There is no combinational path from load, zstart, zinc, count, phrase_mode or srcz_ready to any output.
- load sampled at edge E0 → srcz_valid=1 in the cycle after E0.
- Throughput: one phrase per cycle while srcz_ready=1.
- Final handshake at edge En → done=1 in the cycle after En, srcz_valid=0 in that cycle, IDLE after that.
- count=0 load at E0 → done=1 in the cycle after E0; srcz_valid never asserted.

## Structure
- Shared blitter package holds:
  - PIX_PER_PHRASE=4, ZW=16, ZACC_W=32
  - state enum {IDLE, RUN, DONE}
- Sub-module zlane_add: inputs z_acc, zinc, lane index (0–3), lane enable; output 16-bit lane Z.
- srcz_gen instantiates four zlane_add plus the accumulator/advance adder (0–4 × zinc).

## Test plan
- Phrase span: zstart=0x0010_0000, zinc=0x0001_0000, count=8, phrase_mode=1, ready=1 → srczplo=0x0011_0010, srczphi=0x0013_0012, then 0x0015_0014 / 0x0017_0016, pix_en=0xF both. done pulse follows; busy drops the cycle after done.
- Partial last phrase: same as above with count=6 → second phrase srczplo=0x0015_0014, srczphi=0x0000_0000, pix_en=0x3.
- Backpressure: ready held low 3 cycles mid-span → outputs bit-stable, z_acc not advanced. Sequence resumes unchanged when ready rises.
- Wrap / negative step:
  - zstart=0xFFFF_8000, zinc=0x0000_8000, count=4 → lanes 0xFFFF, 0x0000, 0x0000, 0x0001.
  - zinc=0xFFFF_0000 from zstart=0x0002_0000 → lanes 0x0002, 0x0001, 0x0000, 0xFFFF.
- Pixel mode: phrase_mode=0, count=3, zinc=0x0002_0000 → three single-lane phrases with lane 0 = Z, Z+2, Z+4; pix_en=0x1; lanes 1–3 are 0.
- Abort and zero-length cases:
  - load mid-span → new span starts the next cycle, no done for the old span.
  - reset mid-span → all outputs 0 next cycle.
  - count=0 → done pulse only, srcz_valid never asserted.
